// File: rtl/dmem_arbiter_if.sv
// Bundle of the core, host and dmem signals around dmem_arbiter.
// The arbiter connects through the slave modport; the requesters and the memory connect through master.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_stall;
    logic [DATA_W-1:0] core_rdata;
    logic              core_rvalid;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rdata, core_rvalid,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rdata, host_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rdata, core_rvalid,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rdata, host_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the core LDM/STM port and the host/loader port.
// Optional macro DMEM_ARBITER_PERF_EN adds stall and host-grant performance counters.
module dmem_arbiter #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned HOST_WAIT_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    dmem_arbiter_if.slave       bus
`ifdef DMEM_ARBITER_PERF_EN
    ,
    output logic [31:0]         perf_stall_cycles,
    output logic [31:0]         perf_host_grants,
    output logic [31:0]         perf_forced_grants
`endif
);
    localparam int unsigned LAT_W  = 3;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [WAIT_W-1:0]   host_wait_q, host_wait_d;
    logic                tag_q, tag_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

    logic                core_gnt_c, host_gnt_c;
    logic                core_rvalid_c, host_rvalid_c;
    logic                mem_en_c, mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    // Arbitration, memory issue, read-latency tracking and read-data steering.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        host_wait_d   = host_wait_q;
        tag_d         = tag_q;
        core_rdata_d  = core_rdata_q;
        host_rdata_d  = host_rdata_q;
        core_gnt_c    = 1'b0;
        host_gnt_c    = 1'b0;
        core_rvalid_c = 1'b0;
        host_rvalid_c = 1'b0;
        mem_en_c      = 1'b0;
        mem_we_c      = 1'b0;
        mem_addr_c    = '0;
        mem_wdata_c   = '0;

        unique case (state_q)
            IDLE: begin
                if (!rst) begin
                    if (bus.core_req &&
                        !(bus.host_req && host_wait_q == WAIT_W'(HOST_WAIT_MAX))) begin
                        core_gnt_c = 1'b1;
                    end else if (bus.host_req) begin
                        host_gnt_c = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!rst) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                    if (lat_cnt_q == LAT_W'(1)) begin
                        state_d       = IDLE;
                        core_rvalid_c = !tag_q;
                        host_rvalid_c = tag_q;
                    end
                end
            end
        endcase

        if (core_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.core_we;
            mem_addr_c  = bus.core_addr;
            mem_wdata_c = bus.core_wdata;
        end else if (host_gnt_c) begin
            mem_en_c    = 1'b1;
            mem_we_c    = bus.host_we;
            mem_addr_c  = bus.host_addr;
            mem_wdata_c = bus.host_wdata;
        end

        // Reads hold the port busy until the data returns; tag remembers the owner.
        if (mem_en_c && !mem_we_c) begin
            state_d   = BUSY;
            lat_cnt_d = LAT_W'(MEM_LAT);
            tag_d     = host_gnt_c;
        end

        if (core_rvalid_c) core_rdata_d = bus.mem_rdata;
        if (host_rvalid_c) host_rdata_d = bus.mem_rdata;

        if (!bus.host_req || host_gnt_c) begin
            host_wait_d = '0;
        end else if (host_wait_q < WAIT_W'(HOST_WAIT_MAX)) begin
            host_wait_d = host_wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lat_cnt_q    <= '0;
            host_wait_q  <= '0;
            tag_q        <= 1'b0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            lat_cnt_q    <= lat_cnt_d;
            host_wait_q  <= host_wait_d;
            tag_q        <= tag_d;
            core_rdata_q <= core_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // Read data passes straight through in the rvalid cycle, then holds.
    assign bus.core_rdata  = core_rdata_d;
    assign bus.host_rdata  = host_rdata_d;
    assign bus.core_rvalid = core_rvalid_c;
    assign bus.host_rvalid = host_rvalid_c;
    assign bus.host_gnt    = host_gnt_c;
    assign bus.core_stall  = bus.core_req & ~(core_gnt_c & bus.core_we) & ~core_rvalid_c;
    assign bus.mem_en      = mem_en_c;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.mem_wdata   = mem_wdata_c;

`ifdef DMEM_ARBITER_PERF_EN
    logic [31:0] perf_stall_cycles_q,  perf_stall_cycles_d;
    logic [31:0] perf_host_grants_q,   perf_host_grants_d;
    logic [31:0] perf_forced_grants_q, perf_forced_grants_d;

    // A host grant while the core also requests can only come from the wait threshold.
    always_comb begin
        perf_stall_cycles_d  = perf_stall_cycles_q;
        perf_host_grants_d   = perf_host_grants_q;
        perf_forced_grants_d = perf_forced_grants_q;
        if (bus.core_stall)            perf_stall_cycles_d  = perf_stall_cycles_q + 32'd1;
        if (host_gnt_c)                perf_host_grants_d   = perf_host_grants_q + 32'd1;
        if (host_gnt_c && bus.core_req) perf_forced_grants_d = perf_forced_grants_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles_q  <= '0;
            perf_host_grants_q   <= '0;
            perf_forced_grants_q <= '0;
        end else begin
            perf_stall_cycles_q  <= perf_stall_cycles_d;
            perf_host_grants_q   <= perf_host_grants_d;
            perf_forced_grants_q <= perf_forced_grants_d;
        end
    end

    assign perf_stall_cycles  = perf_stall_cycles_q;
    assign perf_host_grants   = perf_host_grants_q;
    assign perf_forced_grants = perf_forced_grants_q;
`endif
endmodule
